// File: rtl/jregfile_pkg.sv
// Shared constants and move-FSM state encoding for the register file.
package jregfile_pkg;

  localparam int ARCH_BITS_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENABLE = 2'd1,
    S_SET    = 2'd2
  } mv_state_e;

endpackage

// File: rtl/jregfile_cell.sv
// One architectural word: clocked register with sync reset and set enable.
module jregcell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else if (set) begin
      word_q <= d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/jregfile.sv
// Register file with tri-state read bus and internal reg-to-reg move FSM.
module jregfile
  import jregfile_pkg::*;
#(
  parameter int ARCH_BITS = ARCH_BITS_DEF,
  parameter int NREGS     = 4,
  parameter int AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        wsel,
  input  logic                 ws,
  input  logic [ARCH_BITS-1:0] bis,
  input  logic [AW-1:0]        rsel,
  input  logic                 we,
  inout  wire  [ARCH_BITS-1:0] bos,
  input  logic                 mv_req,
  input  logic [AW-1:0]        mv_src,
  input  logic [AW-1:0]        mv_dst,
  output logic                 mv_busy,
  output logic                 mv_done
);

  mv_state_e              state_q, state_d;
  logic [ARCH_BITS-1:0]   tmp_q, tmp_d;
  logic [AW-1:0]          dst_q, dst_d;
  logic                   done_q, done_d;
  logic                   mv_set;
  logic [ARCH_BITS-1:0]   regs [NREGS];
  logic [ARCH_BITS-1:0]   cell_d;
  logic                   wr_ok;

  assign mv_busy = (state_q != S_IDLE);
  assign mv_done = done_q;
  assign wr_ok   = ws && !mv_busy;
  assign cell_d  = mv_set ? tmp_q : bis;

  // Host writes and the move write are exclusive: ws is dropped while busy.
  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    logic set_g;
    assign set_g = (wr_ok && (wsel == AW'(g)))
                 || (mv_set && (dst_q == AW'(g)));
    jregcell #(.W(ARCH_BITS)) u_cell (
      .clk   (clk),
      .reset (reset),
      .set   (set_g),
      .d     (cell_d),
      .q     (regs[g])
    );
  end

  always_comb begin
    state_d = state_q;
    tmp_d   = tmp_q;
    dst_d   = dst_q;
    done_d  = 1'b0;
    mv_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mv_req) begin
          state_d = S_ENABLE;
          tmp_d   = regs[mv_src];
          dst_d   = mv_dst;
        end
      end
      S_ENABLE: state_d = S_SET;
      S_SET: begin
        state_d = S_IDLE;
        mv_set  = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmp_q   <= '0;
      dst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmp_q   <= tmp_d;
      dst_q   <= dst_d;
      done_q  <= done_d;
    end
  end

  assign bos = we ? regs[rsel] : 'z;

endmodule

// File: tb/tb_jregfile.sv
// Directed self-checking bench for jregfile.
module tb_jregfile;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] wsel, rsel, mv_src, mv_dst;
  logic       ws, we, mv_req;
  logic [7:0] bis;
  wire  [7:0] bos;
  logic       mv_busy, mv_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Undriven bus floats high so a released bus is observable.
  pullup (bos);

  jregfile #(.ARCH_BITS(8), .NREGS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .wsel    (wsel),
    .ws      (ws),
    .bis     (bis),
    .rsel    (rsel),
    .we      (we),
    .bos     (bos),
    .mv_req  (mv_req),
    .mv_src  (mv_src),
    .mv_dst  (mv_dst),
    .mv_busy (mv_busy),
    .mv_done (mv_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input int r, input logic [7:0] e);
    rsel = 2'(r);
    we   = 1'b1;
    #1;
    chk(tag, bos, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input logic [7:0] d);
    wsel = 2'(r);
    bis  = d;
    ws   = 1'b1;
    tick();
    ws   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ws = 1'b0; we = 1'b0; mv_req = 1'b0;
    wsel = '0; rsel = '0; mv_src = '0; mv_dst = '0; bis = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", {7'd0, mv_busy}, 8'h00);
    chk("rst_done", {7'd0, mv_done}, 8'h00);
    for (int i = 0; i < 4; i++) rd($sformatf("rst_r%0d", i), i, 8'h00);
    we = 1'b0;
    #1;
    chk("bus_released", bos, 8'hFF);

    // Plain write, visible next cycle
    wr(2, 8'hA5);
    rd("wr_r2", 2, 8'hA5);
    rd("wr_r0", 0, 8'h00);
    rd("wr_r1", 1, 8'h00);
    rd("wr_r3", 3, 8'h00);

    // Move 1 -> 3, with a write and a second request while busy
    wr(1, 8'h3C);
    mv_src = 2'd1; mv_dst = 2'd3; mv_req = 1'b1;
    tick();
    mv_req = 1'b1; mv_src = 2'd0; mv_dst = 2'd1;
    wsel = 2'd0; bis = 8'hFF; ws = 1'b1;
    chk("mv_en_busy", {7'd0, mv_busy}, 8'h01);
    chk("mv_en_done", {7'd0, mv_done}, 8'h00);
    tick();
    mv_req = 1'b0; ws = 1'b0;
    chk("mv_set_busy", {7'd0, mv_busy}, 8'h01);
    rd("mv_set_r3_old", 3, 8'h00);
    tick();
    chk("mv_fin_busy", {7'd0, mv_busy}, 8'h00);
    chk("mv_fin_done", {7'd0, mv_done}, 8'h01);
    rd("mv_r3", 3, 8'h3C);
    tick();
    chk("mv_done_once", {7'd0, mv_done}, 8'h00);
    chk("mv_no_second", {7'd0, mv_busy}, 8'h00);
    rd("busy_wr_lost_r0", 0, 8'h00);
    rd("mv_r1_kept", 1, 8'h3C);

    // Same-cycle write and move: move sees pre-write source
    wr(1, 8'h22);
    wsel = 2'd1; bis = 8'h11; ws = 1'b1;
    mv_src = 2'd1; mv_dst = 2'd2; mv_req = 1'b1;
    tick();
    ws = 1'b0; mv_req = 1'b0;
    rd("same_r1", 1, 8'h11);
    tick();
    tick();
    chk("same_done", {7'd0, mv_done}, 8'h01);
    rd("same_r2", 2, 8'h22);

    // Back-to-back move issued in the done cycle: 3 -> 0
    mv_src = 2'd3; mv_dst = 2'd0; mv_req = 1'b1;
    tick();
    mv_req = 1'b0;
    chk("b2b_busy", {7'd0, mv_busy}, 8'h01);
    tick();
    tick();
    chk("b2b_done", {7'd0, mv_done}, 8'h01);
    rd("b2b_r0", 0, 8'h3C);

    // src == dst
    mv_src = 2'd2; mv_dst = 2'd2; mv_req = 1'b1;
    tick();
    mv_req = 1'b0;
    tick();
    chk("self_busy", {7'd0, mv_busy}, 8'h01);
    tick();
    chk("self_done", {7'd0, mv_done}, 8'h01);
    rd("self_r2", 2, 8'h22);

    // Reset in SET aborts the move and beats a concurrent write
    mv_src = 2'd1; mv_dst = 2'd3; mv_req = 1'b1;
    tick();
    mv_req = 1'b0;
    tick();
    chk("abort_in_set", {7'd0, mv_busy}, 8'h01);
    reset = 1'b1; wsel = 2'd2; bis = 8'h77; ws = 1'b1;
    tick();
    ws = 1'b0;
    chk("abort_busy", {7'd0, mv_busy}, 8'h00);
    chk("abort_done", {7'd0, mv_done}, 8'h00);
    rd("abort_rst_r3", 3, 8'h00);
    rd("abort_rst_r2", 2, 8'h00);
    reset = 1'b0;
    tick();
    chk("abort_no_done", {7'd0, mv_done}, 8'h00);
    rd("abort_r3", 3, 8'h00);
    rd("abort_r1", 1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
